bsg_fsb_node_out_arbiter: RTL and testbench
===========================================

Name: bsg_fsb_node_out_arbiter

Overview:
- Round-robin arbiter that shares one FSB output channel (ring side of bsg_comm_link, core_node_v_i/data_i/yumi_o) among nodes_p requesting chipset nodes: NASTI slave, HTIF slave and trace replay.
- Boot gating: until boot_done_i, only the boot node (trace replay) may be granted.
- The winning packet is registered in a one-entry output stage, so downstream timing is decoupled from arbitration.

Parameters:
- nodes_p, 3, number of requesters (>=2)
- ring_width_p, 80, FSB packet width in bits
- boot_id_p, 2, requester index with exclusive access before boot_done_i
- lg_nodes_lp, `BSG_SAFE_CLOG2(nodes_p)`, width of the requester index

Ports:
- clk_i  in  1  core clock
- async_reset_n_i  in  1  asynchronous active-low reset
- en_i  in  1  arbitration enable (node enable from comm link)
- boot_done_i  in  1  trace replay done; releases non-boot requesters
- mask_i  in  nodes_p  per-requester enable; 1 = eligible
- v_i  in  nodes_p  requester packet valid
- data_i  in  nodes_p x ring_width_p  requester packets (unpacked array)
- yumi_o  out  nodes_p  one-hot; requester packet consumed this cycle
- v_o  out  1  output packet valid
- data_o  out  ring_width_p  output packet
- src_id_o  out  lg_nodes_lp  index of requester whose packet is in data_o
- yumi_i  in  1  downstream consumes data_o this cycle

Behaviour:
- Reset (async assert, sync release through the flop clear):
  - v_o=0, data_o=0, src_id_o=0
  - last_grant_r=nodes_p-1, so requester 0 has first priority
  - yumi_o forced to 0 while async_reset_n_i=0
- Eligibility per requester i: elig[i] = v_i[i] & mask_i[i] & (boot_done_i | i==boot_id_p).
- Load condition: load = en_i & |elig & (~v_o | yumi_i). Output reg empty or draining the same cycle gives full 1 packet/cycle throughput.
- Pick rule: first eligible index scanning last_grant_r+1, +2, ... with wrap modulo nodes_p. Pick is combinational.
- On load, in the same cycle:
  - yumi_o[g]=1; all other yumi_o bits 0
  - next edge: data_o<=data_i[g], src_id_o<=g, v_o<=1, last_grant_r<=g
- yumi_o is never asserted without v_i of that index. Requesters must hold v_i/data_i stable until yumi_o.
- Latency: 1 cycle from yumi_o[g] to v_o with that packet.
- Output hold: v_o=1 & ~yumi_i keeps data_o/src_id_o stable, and no yumi_o is issued.
- Drain: v_o=1 & yumi_i & ~load sets v_o<=0; data_o holds its last value.
- en_i=0: no new grants, last_grant_r frozen; a packet already in the output reg still presents and drains normally.
- boot_done_i 0->1 in the same cycle as a request takes effect combinationally that cycle. 1->0 is illegal; behaviour is undefined, no check required.
- mask_i changes apply the same cycle. Masking a requester never aborts a packet already in the output reg.
- Single eligible requester: it is granted every load cycle regardless of last_grant_r (no bubble).
- Fairness: with all requesters continuously eligible and yumi_i=1, the grant sequence is 0,1,...,nodes_p-1,0,...
- Reset mid-operation: the packet in the output reg is dropped. A requester that has not been yumi'd retains its packet.

Decomposition:
- Shared package bsg_fsb_pkg:
  - ring_width constant (ring_bytes*channel_width = 80)
  - node id constants: htif=0, nasti=1, replay=2
- Sub-module bsg_fsb_rr_picker: combinational rotate/priority-encode; inputs elig and last_grant; outputs grant one-hot, grant index, any.
- Top level holds last_grant_r, the output register and yumi_o gating.

Test Plan:
- Reset then boot gating: boot_done_i=0, v_i=3'b111, mask=111, yumi_i=1 -> only requester 2 yumi'd. v_o rises next cycle with src_id_o=2; requesters 0/1 never yumi'd over 10 cycles.
- Round robin: boot_done_i=1, all valid continuously, yumi_i=1 -> src_id_o sequence 0,1,2,0,1,2 with v_o=1 every cycle after the first.
- Backpressure: yumi_i=0 for 5 cycles with v_o=1 -> data_o/src_id_o stable, yumi_o=0. yumi_i=1 -> next requester granted the same cycle, new data the next cycle.
- Mask and en_i: mask_i=3'b101 -> grants alternate 0,2. en_i=0 for 3 cycles -> no yumi_o, existing v_o drains once yumi_i=1, then v_o=0.
- Single requester: only v_i[1]=1, yumi_i=1 -> yumi_o=3'b010 every cycle, data_o tracks data_i[1] with 1-cycle latency, no bubbles.
- Async reset asserted with v_o=1 mid-stream -> v_o=0 immediately. After release, first grant goes to the lowest eligible index ≥0.

Source files
------------

// File: rtl/bsg_fsb_pkg.sv
// Shared FSB definitions: ring packet width, chipset node ids and small helpers.
package bsg_fsb_pkg;

    localparam int ring_bytes    = 10;
    localparam int channel_width = 8;
    localparam int ring_width    = ring_bytes * channel_width;

    typedef enum logic [1:0] {
        node_htif   = 2'd0,
        node_nasti  = 2'd1,
        node_replay = 2'd2
    } node_id_e;

    // Index width that never collapses to zero bits.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_fsb_rr_picker.sv
// Combinational round-robin pick: first eligible index after last_grant, wrapping.
module bsg_fsb_rr_picker
    import bsg_fsb_pkg::*;
#(
    parameter int nodes_p     = 3,
    parameter int lg_nodes_lp = safe_clog2(nodes_p)
) (
    input  logic [nodes_p-1:0]     elig,
    input  logic [lg_nodes_lp-1:0] last_grant,
    output logic [nodes_p-1:0]     grant_oh,
    output logic [lg_nodes_lp-1:0] grant_id,
    output logic                   any
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant_oh = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        for (int k = 1; k <= nodes_p; k++) begin
            idx = (int'(last_grant) + k) % nodes_p;
            if (!any && elig[idx]) begin
                any           = 1'b1;
                grant_id      = lg_nodes_lp'(idx);
                grant_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_fsb_node_out_arbiter.sv
// Shares one FSB output channel among chipset nodes with round-robin priority,
// boot gating and a one-entry registered output stage.
module bsg_fsb_node_out_arbiter
    import bsg_fsb_pkg::*;
#(
    parameter int nodes_p      = 3,
    parameter int ring_width_p = ring_width,
    parameter int boot_id_p    = int'(node_replay),
    parameter int lg_nodes_lp  = safe_clog2(nodes_p)
) (
    input  logic                    clk_i,
    input  logic                    async_reset_n_i,
    input  logic                    en_i,
    input  logic                    boot_done_i,
    input  logic [nodes_p-1:0]      mask_i,
    input  logic [nodes_p-1:0]      v_i,
    input  logic [ring_width_p-1:0] data_i [nodes_p],
    output logic [nodes_p-1:0]      yumi_o,
    output logic                    v_o,
    output logic [ring_width_p-1:0] data_o,
    output logic [lg_nodes_lp-1:0]  src_id_o,
    input  logic                    yumi_i
);

    logic [nodes_p-1:0]     elig;
    logic [nodes_p-1:0]     grant_oh;
    logic [lg_nodes_lp-1:0] grant_id;
    logic [lg_nodes_lp-1:0] last_grant_r;
    logic                   any;
    logic                   load;

    // Before boot completes only the trace-replay node may reach the ring.
    always_comb begin
        elig = '0;
        for (int i = 0; i < nodes_p; i++) begin
            elig[i] = v_i[i] & mask_i[i] & (boot_done_i | (i == boot_id_p));
        end
    end

    bsg_fsb_rr_picker #(
        .nodes_p     (nodes_p),
        .lg_nodes_lp (lg_nodes_lp)
    ) picker (
        .elig       (elig),
        .last_grant (last_grant_r),
        .grant_oh   (grant_oh),
        .grant_id   (grant_id),
        .any        (any)
    );

    // Loading while the current packet drains keeps one packet per cycle.
    assign load   = en_i & any & (~v_o | yumi_i);
    assign yumi_o = (load & async_reset_n_i) ? grant_oh : '0;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            v_o          <= 1'b0;
            data_o       <= '0;
            src_id_o     <= '0;
            last_grant_r <= lg_nodes_lp'(nodes_p - 1);
        end else if (load) begin
            v_o          <= 1'b1;
            data_o       <= data_i[grant_id];
            src_id_o     <= grant_id;
            last_grant_r <= grant_id;
        end else if (yumi_i) begin
            v_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bsg_fsb_node_out_arbiter.sv
// Randomized and directed bench for bsg_fsb_node_out_arbiter against a behavioural model.
module tb_bsg_fsb_node_out_arbiter;

    localparam int N    = 3;
    localparam int W    = 80;
    localparam int BOOT = 2;
    localparam int LG   = 2;

    logic          clk;
    logic          rst_n;
    logic          en_i;
    logic          boot_done_i;
    logic [N-1:0]  mask_i;
    logic [N-1:0]  v_i;
    logic [W-1:0]  req_data [N];
    logic [N-1:0]  yumi_o;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic [LG-1:0] src_id_o;
    logic          yumi_i;

    int total = 0;
    int bad   = 0;

    // Behavioural model: the output register as a one-slot buffer plus last winner.
    int           m_last;
    bit           m_v;
    logic [W-1:0] m_data;
    int           m_src;
    logic [N-1:0] exp_yumi;
    logic [N-1:0] obs_yumi;

    bsg_fsb_node_out_arbiter dut (
        .clk_i           (clk),
        .async_reset_n_i (rst_n),
        .en_i            (en_i),
        .boot_done_i     (boot_done_i),
        .mask_i          (mask_i),
        .v_i             (v_i),
        .data_i          (req_data),
        .yumi_o          (yumi_o),
        .v_o             (v_o),
        .data_o          (data_o),
        .src_id_o        (src_id_o),
        .yumi_i          (yumi_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_pkt();
        return W'({$urandom, $urandom, $urandom});
    endfunction

    task automatic model_reset();
        m_last = N - 1;
        m_v    = 0;
        m_data = '0;
        m_src  = 0;
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic tick();
        bit found;
        bit ld;
        int g;
        #1;
        found = 0;
        g     = 0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (!found && v_i[idx] && mask_i[idx] && (boot_done_i || idx == BOOT)) begin
                found = 1;
                g     = idx;
            end
        end
        ld       = en_i && found && (!m_v || yumi_i);
        exp_yumi = '0;
        if (ld) exp_yumi[g] = 1'b1;
        obs_yumi = yumi_o;
        @(posedge clk);
        if (ld) begin
            m_v    = 1;
            m_data = req_data[g];
            m_src  = g;
            m_last = g;
        end else if (m_v && yumi_i) begin
            m_v = 0;
        end
        @(negedge clk);
        if (ld) req_data[g] = rand_pkt();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en_i = 1'b1; boot_done_i = 1'b0; mask_i = '1; v_i = '1; yumi_i = 1'b1;
        for (int i = 0; i < N; i++) req_data[i] = rand_pkt();
        model_reset();
        repeat (2) @(negedge clk);
        total++;
        if (v_o !== 1'b0 || src_id_o !== '0 || data_o !== '0) begin
            bad++;
            $display("FAIL reset_out: v_o=%b src=%0d data=%h want 0/0/0", v_o, src_id_o, data_o);
        end
        total++;
        if (yumi_o !== '0) begin
            bad++;
            $display("FAIL reset_yumi: got %b want 000", yumi_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_boot_gating();
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (obs_yumi !== 3'b100) begin
                bad++;
                $display("FAIL boot_yumi c%0d: got %b want 100", c, obs_yumi);
            end
            total++;
            if (v_o !== 1'b1 || src_id_o !== LG'(BOOT) || data_o !== m_data) begin
                bad++;
                $display("FAIL boot_out c%0d: v=%b src=%0d data=%h want 1/%0d/%h", c, v_o, src_id_o, data_o, BOOT, m_data);
            end
        end
    endtask

    task automatic test_round_robin();
        boot_done_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (obs_yumi !== exp_yumi || obs_yumi !== N'(1 << (c % N))) begin
                bad++;
                $display("FAIL rr_yumi c%0d: got %b want %b", c, obs_yumi, exp_yumi);
            end
            total++;
            if (v_o !== 1'b1 || src_id_o !== LG'(c % N) || data_o !== m_data) begin
                bad++;
                $display("FAIL rr_out c%0d: v=%b src=%0d data=%h want 1/%0d/%h", c, v_o, src_id_o, data_o, c % N, m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        yumi_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (obs_yumi !== '0) begin
                bad++;
                $display("FAIL bp_yumi c%0d: got %b want 000", c, obs_yumi);
            end
            total++;
            if (v_o !== 1'b1 || src_id_o !== LG'(m_src) || data_o !== m_data) begin
                bad++;
                $display("FAIL bp_hold c%0d: v=%b src=%0d data=%h want 1/%0d/%h", c, v_o, src_id_o, data_o, m_src, m_data);
            end
        end
        yumi_i = 1'b1;
        tick();
        total++;
        if (obs_yumi !== exp_yumi || obs_yumi === '0) begin
            bad++;
            $display("FAIL bp_release_yumi: got %b want %b", obs_yumi, exp_yumi);
        end
        total++;
        if (v_o !== 1'b1 || src_id_o !== LG'(m_src) || data_o !== m_data) begin
            bad++;
            $display("FAIL bp_release_out: src=%0d data=%h want %0d/%h", src_id_o, data_o, m_src, m_data);
        end
    endtask

    task automatic test_mask_en();
        int prev;
        mask_i = 3'b101;
        prev   = -1;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (obs_yumi !== exp_yumi || obs_yumi[1] !== 1'b0) begin
                bad++;
                $display("FAIL mask_yumi c%0d: got %b want %b", c, obs_yumi, exp_yumi);
            end
            total++;
            if (src_id_o !== LG'(m_src) || int'(src_id_o) == prev || data_o !== m_data) begin
                bad++;
                $display("FAIL mask_out c%0d: src=%0d data=%h want %0d/%h", c, src_id_o, data_o, m_src, m_data);
            end
            prev = int'(src_id_o);
        end
        mask_i = '1;
        en_i   = 1'b0;
        yumi_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (obs_yumi !== '0 || v_o !== 1'b1 || data_o !== m_data) begin
                bad++;
                $display("FAIL en_hold c%0d: yumi=%b v=%b want 000/1", c, obs_yumi, v_o);
            end
        end
        yumi_i = 1'b1;
        tick();
        total++;
        if (obs_yumi !== '0 || v_o !== 1'b0) begin
            bad++;
            $display("FAIL en_drain: yumi=%b v=%b want 000/0", obs_yumi, v_o);
        end
        en_i = 1'b1;
    endtask

    task automatic test_single();
        v_i = 3'b010;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (obs_yumi !== 3'b010) begin
                bad++;
                $display("FAIL single_yumi c%0d: got %b want 010", c, obs_yumi);
            end
            total++;
            if (v_o !== 1'b1 || src_id_o !== 2'd1 || data_o !== m_data) begin
                bad++;
                $display("FAIL single_out c%0d: v=%b src=%0d data=%h want 1/1/%h", c, v_o, src_id_o, data_o, m_data);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(v_i[i] && !exp_yumi[i])) v_i[i] = 1'($urandom_range(0, 1));
            end
            mask_i = N'($urandom);
            en_i   = ($urandom_range(0, 7) != 0);
            yumi_i = 1'($urandom_range(0, 1));
            tick();
            total++;
            if (obs_yumi !== exp_yumi) begin
                bad++;
                $display("FAIL rand_yumi c%0d: got %b want %b", c, obs_yumi, exp_yumi);
            end
            total++;
            if (v_o !== m_v || (m_v && (src_id_o !== LG'(m_src) || data_o !== m_data))) begin
                bad++;
                $display("FAIL rand_out c%0d: v=%b src=%0d data=%h want %b/%0d/%h", c, v_o, src_id_o, data_o, m_v, m_src, m_data);
            end
        end
    endtask

    task automatic test_reset_midstream();
        en_i = 1'b1; mask_i = '1; v_i = '1; yumi_i = 1'b1;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (v_o !== 1'b0 || yumi_o !== '0) begin
            bad++;
            $display("FAIL midreset_clear: v=%b yumi=%b want 0/000", v_o, yumi_o);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (obs_yumi !== 3'b001 || obs_yumi !== exp_yumi) begin
            bad++;
            $display("FAIL midreset_first: got %b want 001", obs_yumi);
        end
        total++;
        if (v_o !== 1'b1 || src_id_o !== 2'd0 || data_o !== m_data) begin
            bad++;
            $display("FAIL midreset_out: v=%b src=%0d data=%h want 1/0/%h", v_o, src_id_o, data_o, m_data);
        end
    endtask

    initial begin
        exp_yumi = '0;
        test_reset();
        test_boot_gating();
        test_round_robin();
        test_backpressure();
        test_mask_en();
        test_single();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
